dtree_seq_eval: RTL

DTREE_SEQ_EVAL -- requirements
Module: dtree_seq_eval

---
 rtl/dtree_pkg.sv | 40 ++++
 rtl/dtree_node_ram.sv | 36 +++
 rtl/dtree_seq_eval.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree evaluator: FSM states,
// default sizing and the node-word field placement.
package dtree_pkg;

    localparam int DEF_N_FEAT    = 5;
    localparam int DEF_FEAT_W    = 8;
    localparam int DEF_CLASS_W   = 5;
    localparam int DEF_N_NODES   = 32;
    localparam int DEF_MAX_DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        NF_RIGHT,
        NF_LEFT,
        NF_THR,
        NF_SHIFT,
        NF_FIDX,
        NF_LEAF
    } node_field_e;

    // Node word, MSB to LSB: leaf, fidx, shift, thr, left, right.
    function automatic int node_lsb(input node_field_e f, input int fidx_w,
                                    input int sh_w, input int feat_w, input int addr_w);
        case (f)
            NF_RIGHT: return 0;
            NF_LEFT:  return addr_w;
            NF_THR:   return 2 * addr_w;
            NF_SHIFT: return 2 * addr_w + feat_w;
            NF_FIDX:  return 2 * addr_w + feat_w + sh_w;
            NF_LEAF:  return 2 * addr_w + feat_w + sh_w + fidx_w;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/dtree_node_ram.sv
// Node table: one synchronous write port, one combinational read port,
// cleared to all-zero words by reset.
module dtree_node_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_wr_ok = ({1'b0, i_waddr} < LP_DEPTH);
    assign w_rd_ok = ({1'b0, i_raddr} < LP_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: walks one node per cycle from root 0
// until a leaf, a malformed node, or the visit limit is hit.
module dtree_seq_eval
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = DEF_N_FEAT,
    parameter int FEAT_W    = DEF_FEAT_W,
    parameter int CLASS_W   = DEF_CLASS_W,
    parameter int N_NODES   = DEF_N_NODES,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    localparam int ADDR_W   = $clog2(N_NODES),
    localparam int FIDX_W   = $clog2(N_FEAT),
    localparam int SH_W     = $clog2(FEAT_W),
    localparam int NODE_W   = 1 + FIDX_W + SH_W + FEAT_W + 2 * ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_FEAT*FEAT_W-1:0] feat_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CLASS_W-1:0]       class_o,
    output logic                     err_o,
    input  logic                     cfg_we_i,
    input  logic [ADDR_W-1:0]        cfg_addr_i,
    input  logic [NODE_W-1:0]        cfg_data_i,
    output logic                     cfg_ready_o
);

    localparam int OFF_RIGHT = node_lsb(NF_RIGHT, FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int OFF_LEFT  = node_lsb(NF_LEFT,  FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int OFF_THR   = node_lsb(NF_THR,   FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int OFF_SHIFT = node_lsb(NF_SHIFT, FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int OFF_FIDX  = node_lsb(NF_FIDX,  FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int OFF_LEAF  = node_lsb(NF_LEAF,  FIDX_W, SH_W, FEAT_W, ADDR_W);
    localparam int DEP_W     = $clog2(MAX_DEPTH + 1);

    localparam logic [ADDR_W:0]  LP_NODES = (ADDR_W+1)'(N_NODES);
    localparam logic [FIDX_W:0]  LP_NFEAT = (FIDX_W+1)'(N_FEAT);
    localparam logic [DEP_W-1:0] LP_DLAST = DEP_W'(MAX_DEPTH - 1);

    state_e                         r_state;
    logic [N_FEAT-1:0][FEAT_W-1:0]  r_feat;
    logic [ADDR_W-1:0]              r_ptr;
    logic [DEP_W-1:0]               r_depth;
    logic [CLASS_W-1:0]             r_class;
    logic                           r_err;
    logic                           r_out_valid;

    logic [NODE_W-1:0]  w_node;
    logic               w_leaf;
    logic [FIDX_W-1:0]  w_fidx;
    logic [SH_W-1:0]    w_shift;
    logic [FEAT_W-1:0]  w_thr;
    logic [ADDR_W-1:0]  w_left;
    logic [ADDR_W-1:0]  w_right;
    logic [ADDR_W-1:0]  w_child;
    logic [FEAT_W-1:0]  w_feat;
    logic               w_fidx_ok;
    logic               w_child_ok;
    logic               w_last;
    logic               w_cfg_wr;

    // Writes are only taken in IDLE, so a walk always sees a stable table.
    assign w_cfg_wr = cfg_we_i && (r_state == S_IDLE);

    dtree_node_ram #(
        .DEPTH (N_NODES),
        .AW    (ADDR_W),
        .DW    (NODE_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_cfg_wr),
        .i_waddr (cfg_addr_i),
        .i_wdata (cfg_data_i),
        .i_raddr (r_ptr),
        .o_rdata (w_node)
    );

    assign w_leaf  = w_node[OFF_LEAF];
    assign w_fidx  = w_node[OFF_FIDX  +: FIDX_W];
    assign w_shift = w_node[OFF_SHIFT +: SH_W];
    assign w_thr   = w_node[OFF_THR   +: FEAT_W];
    assign w_left  = w_node[OFF_LEFT  +: ADDR_W];
    assign w_right = w_node[OFF_RIGHT +: ADDR_W];

    assign w_fidx_ok = ({1'b0, w_fidx} < LP_NFEAT);

    always_comb begin
        w_feat = '0;
        if (w_fidx_ok) w_feat = r_feat[w_fidx];
    end

    assign w_child    = ((w_feat >> w_shift) <= w_thr) ? w_left : w_right;
    assign w_child_ok = ({1'b0, w_child} < LP_NODES);
    assign w_last     = (r_depth == LP_DLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_feat      <= '0;
            r_ptr       <= '0;
            r_depth     <= '0;
            r_class     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_feat  <= feat_i;
                        r_ptr   <= '0;
                        r_depth <= '0;
                        r_state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (w_leaf) begin
                        r_class     <= w_thr[CLASS_W-1:0];
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!w_fidx_ok || !w_child_ok || w_last) begin
                        // r_depth counts finished visits, so w_last marks the final allowed one.
                        r_class     <= '0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_ptr   <= w_child;
                        r_depth <= r_depth + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign cfg_ready_o = (r_state == S_IDLE);
    assign out_valid_o = r_out_valid;
    assign class_o     = r_class;
    assign err_o       = r_err;

endmodule
